// File: rtl/ram32x3_arbiter_if.sv
// ram32x3_arbiter_if: request/grant/read-return bundle between two requesters (A, B) and the arbiter.
// Ports (slave = arbiter side): req/we/addr/wdata per port in; gnt, rd_valid, rd_data per port and init_done out.
// No storage here; gnt is combinational in the arbiter, rd_* and init_done come from registers.
interface ram32x3_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 3
);
   logic          req_a;
   logic          req_b;
   logic          we_a;
   logic          we_b;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] wdata_a;
   logic [DW-1:0] wdata_b;
   logic          gnt_a;
   logic          gnt_b;
   logic          rd_valid_a;
   logic          rd_valid_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic          init_done;

   // Requester side.
   modport master (
      output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      input  gnt_a, gnt_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b, init_done
   );

   // Arbiter side.
   modport slave (
      input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      output gnt_a, gnt_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b, init_done
   );
endinterface

// File: rtl/ram32x3_arbiter.sv
// ram32x3_arbiter: clears the 32x3 RAM after reset, then round-robin shares its single port between A and B.
// Ports: clock, reset (async, active-high), bus (slave modport): per-port req/we/addr/wdata in, gnt/rd_valid/rd_data out, init_done out.
// Latency: grant cycle N -> rd_valid/rd_data in cycle N+2; never stalls, requests simply wait for gnt (held by requester).

// ram32x3: single-port RAM with registered address/data/wren and an unregistered read port.
// A write is committed on the edge after its inputs were registered, so a read registered on
// that same edge already observes the new word (read-after-write safe across cycles).
module ram32x3 #(
   parameter int AW = 5,
   parameter int DW = 3
) (
   input  logic          clock,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] data,
   input  logic          wren,
   output logic [DW-1:0] q
);
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          wren_q;
   logic [DW-1:0] mem_q [0:(1<<AW)-1];

   // No reset: this models a memory macro; the arbiter drives defined values while in reset.
   always_ff @(posedge clock) begin
      addr_q <= address;
      data_q <= data;
      wren_q <= wren;
      if (wren_q) begin
         mem_q[addr_q] <= data_q;
      end
   end

   assign q = mem_q[addr_q];
endmodule

module ram32x3_arbiter #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 3
) (
   input  logic           clock,
   input  logic           reset,
   ram32x3_arbiter_if.slave bus
);
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   // Control state
   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   port_t         ptr_q, ptr_d;
   logic [AW-1:0] hold_addr_q, hold_addr_d;

   // Read-return pipeline: stage 1 is the tag travelling with the RAM access,
   // stage 2 is the per-port valid/data register.
   logic          tag_vld_q, tag_vld_d;
   port_t         tag_id_q, tag_id_d;
   logic          rd_valid_a_q, rd_valid_a_d;
   logic          rd_valid_b_q, rd_valid_b_d;
   logic [DW-1:0] rd_data_a_q, rd_data_a_d;
   logic [DW-1:0] rd_data_b_q, rd_data_b_d;

   // Combinational outputs of the FSM
   logic          gnt_a;
   logic          gnt_b;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic: sweep one word per cycle, leave INIT after the last address
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: grants and RAM port drive
   // ------------------------------------------------------------------
   always_comb begin
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      ram_addr = hold_addr_q;
      ram_data = '0;
      ram_wren = 1'b0;
      if (state_q == ST_INIT) begin
         ram_addr = cnt_q;
         ram_wren = 1'b1;
      end else begin
         // A wins when alone or when the pointer favours it; otherwise B if it asks.
         if (bus.req_a && (!bus.req_b || (ptr_q == PORT_A))) begin
            gnt_a = 1'b1;
         end else if (bus.req_b) begin
            gnt_b = 1'b1;
         end

         if (gnt_a) begin
            ram_addr = bus.addr_a;
            ram_data = bus.wdata_a;
            ram_wren = bus.we_a;
         end else if (gnt_b) begin
            ram_addr = bus.addr_b;
            ram_data = bus.wdata_b;
            ram_wren = bus.we_b;
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath next-values: pointer, held address, read tags, return registers
   // ------------------------------------------------------------------
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_a) begin
         ptr_d = PORT_B;
      end else if (gnt_b) begin
         ptr_d = PORT_A;
      end

      // Idle cycles re-present the last address instead of an arbitrary one.
      hold_addr_d = ram_addr;

      tag_vld_d = (gnt_a && !bus.we_a) || (gnt_b && !bus.we_b);
      tag_id_d  = gnt_b ? PORT_B : PORT_A;

      rd_valid_a_d = tag_vld_q && (tag_id_q == PORT_A);
      rd_valid_b_d = tag_vld_q && (tag_id_q == PORT_B);
      rd_data_a_d  = rd_valid_a_d ? ram_q : rd_data_a_q;
      rd_data_b_d  = rd_valid_b_d ? ram_q : rd_data_b_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q        <= PORT_A;
         hold_addr_q  <= '0;
         tag_vld_q    <= 1'b0;
         tag_id_q     <= PORT_A;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
         rd_data_a_q  <= '0;
         rd_data_b_q  <= '0;
      end else begin
         ptr_q        <= ptr_d;
         hold_addr_q  <= hold_addr_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         rd_valid_a_q <= rd_valid_a_d;
         rd_valid_b_q <= rd_valid_b_d;
         rd_data_a_q  <= rd_data_a_d;
         rd_data_b_q  <= rd_data_b_d;
      end
   end

   // ------------------------------------------------------------------
   // RAM macro
   // ------------------------------------------------------------------
   ram32x3 #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clock   (clock),
      .address (ram_addr),
      .data    (ram_data),
      .wren    (ram_wren),
      .q       (ram_q)
   );

   assign bus.gnt_a      = gnt_a;
   assign bus.gnt_b      = gnt_b;
   assign bus.rd_valid_a = rd_valid_a_q;
   assign bus.rd_valid_b = rd_valid_b_q;
   assign bus.rd_data_a  = rd_data_a_q;
   assign bus.rd_data_b  = rd_data_b_q;
   assign bus.init_done  = (state_q == ST_RUN);
endmodule

// File: tb/tb_ram32x3_arbiter.sv
// tb_ram32x3_arbiter: directed test of the clear sweep, round-robin arbitration and read-return timing.
// Inputs change 1 ns after each rising edge; outputs are sampled 1-2 ns after it.
module tb_ram32x3_arbiter;
   localparam int AW = 5;
   localparam int DW = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   ram32x3_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   ram32x3_arbiter #(
      .DEPTH (32),
      .AW    (AW),
      .DW    (DW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      bus.req_a   = 1'b0;
      bus.req_b   = 1'b0;
      bus.we_a    = 1'b0;
      bus.we_b    = 1'b0;
      bus.addr_a  = '0;
      bus.addr_b  = '0;
      bus.wdata_a = '0;
      bus.wdata_b = '0;
   endtask

   task automatic drive_a(input logic we, input int addr, input int data);
      bus.req_a   = 1'b1;
      bus.we_a    = we;
      bus.addr_a  = AW'(addr);
      bus.wdata_a = DW'(data);
   endtask

   task automatic drive_b(input logic we, input int addr, input int data);
      bus.req_b   = 1'b1;
      bus.we_b    = we;
      bus.addr_b  = AW'(addr);
      bus.wdata_b = DW'(data);
   endtask

   // Reset values; both ports request so that a forced-zero grant is meaningful.
   task automatic test_reset;
      idle_inputs();
      #2 reset = 1'b1;
      bus.req_a = 1'b1;
      bus.req_b = 1'b1;
      step();
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b0) begin n_err++; $display("FAIL reset_gnt_a: got %b want 0", bus.gnt_a); end
      n_cmp++; if (bus.gnt_b !== 1'b0) begin n_err++; $display("FAIL reset_gnt_b: got %b want 0", bus.gnt_b); end
      n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid_a: got %b want 0", bus.rd_valid_a); end
      n_cmp++; if (bus.rd_valid_b !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid_b: got %b want 0", bus.rd_valid_b); end
      n_cmp++; if (bus.rd_data_a !== 3'd0) begin n_err++; $display("FAIL reset_rd_data_a: got %0d want 0", bus.rd_data_a); end
      n_cmp++; if (bus.rd_data_b !== 3'd0) begin n_err++; $display("FAIL reset_rd_data_b: got %0d want 0", bus.rd_data_b); end
      n_cmp++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", bus.init_done); end
      idle_inputs();
      step();
      reset = 1'b0;
   endtask

   // init_done timing, then A reads every word back as zero with 2-cycle latency.
   task automatic test_init_clear;
      for (int i = 1; i <= 31; i++) begin
         step();
         n_cmp++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL init_done_low cyc%0d: got %b want 0", i, bus.init_done); end
      end
      step();
      n_cmp++; if (bus.init_done !== 1'b1) begin n_err++; $display("FAIL init_done_rise: got %b want 1", bus.init_done); end
      for (int c = 0; c < 34; c++) begin
         if (c < 32) drive_a(1'b0, c, 0); else idle_inputs();
         #1;
         if (c < 32) begin
            n_cmp++; if (bus.gnt_a !== 1'b1) begin n_err++; $display("FAIL clr_gnt_a c%0d: got %b want 1", c, bus.gnt_a); end
         end
         if (c >= 2) begin
            n_cmp++; if (bus.rd_valid_a !== 1'b1 || bus.rd_data_a !== 3'd0) begin
               n_err++; $display("FAIL clr_read addr%0d: valid %b data %0d want valid 1 data 0", c - 2, bus.rd_valid_a, bus.rd_data_a);
            end
         end else begin
            n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL clr_early_valid c%0d: got %b want 0", c, bus.rd_valid_a); end
         end
         step();
      end
      n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL clr_tail_valid: got %b want 0", bus.rd_valid_a); end
   endtask

   // A writes i%8 everywhere, B reads it all back; A must see no read returns.
   task automatic test_write_pattern;
      for (int c = 0; c < 32; c++) begin
         drive_a(1'b1, c, c % 8);
         #1;
         n_cmp++; if (bus.gnt_a !== 1'b1) begin n_err++; $display("FAIL wr_gnt_a c%0d: got %b want 1", c, bus.gnt_a); end
         n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL wr_rd_valid_a c%0d: got %b want 0", c, bus.rd_valid_a); end
         step();
      end
      idle_inputs();
      for (int c = 0; c < 34; c++) begin
         if (c < 32) drive_b(1'b0, c, 0); else idle_inputs();
         #1;
         if (c < 32) begin
            n_cmp++; if (bus.gnt_b !== 1'b1) begin n_err++; $display("FAIL rdb_gnt_b c%0d: got %b want 1", c, bus.gnt_b); end
         end
         if (c >= 2) begin
            n_cmp++; if (bus.rd_valid_b !== 1'b1 || bus.rd_data_b !== DW'((c - 2) % 8)) begin
               n_err++; $display("FAIL rdb_data addr%0d: valid %b data %0d want valid 1 data %0d", c - 2, bus.rd_valid_b, bus.rd_data_b, (c - 2) % 8);
            end
         end
         n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL rdb_stray_valid_a c%0d: got %b want 0", c, bus.rd_valid_a); end
         step();
      end
   endtask

   // Both request reads for 10 cycles: A reads addr 1 (=1), B reads addr 2 (=2).
   task automatic test_alternate;
      int pulses_a;
      int pulses_b;
      logic exp_va;
      logic exp_vb;
      pulses_a = 0;
      pulses_b = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 10) begin
            drive_a(1'b0, 1, 0);
            drive_b(1'b0, 2, 0);
         end else begin
            idle_inputs();
         end
         #1;
         if (k < 10) begin
            n_cmp++; if (bus.gnt_a !== ((k % 2) == 0) || bus.gnt_b !== ((k % 2) == 1)) begin
               n_err++; $display("FAIL alt_gnt k%0d: gnt_a %b gnt_b %b want %b %b", k, bus.gnt_a, bus.gnt_b, (k % 2) == 0, (k % 2) == 1);
            end
         end
         exp_va = (k >= 2) && ((k % 2) == 0);
         exp_vb = (k >= 3) && ((k % 2) == 1);
         n_cmp++; if (bus.rd_valid_a !== exp_va || bus.rd_valid_b !== exp_vb) begin
            n_err++; $display("FAIL alt_valid k%0d: a %b b %b want %b %b", k, bus.rd_valid_a, bus.rd_valid_b, exp_va, exp_vb);
         end
         if (bus.rd_valid_a === 1'b1) begin
            pulses_a++;
            n_cmp++; if (bus.rd_data_a !== 3'd1) begin n_err++; $display("FAIL alt_data_a k%0d: got %0d want 1", k, bus.rd_data_a); end
         end
         if (bus.rd_valid_b === 1'b1) begin
            pulses_b++;
            n_cmp++; if (bus.rd_data_b !== 3'd2) begin n_err++; $display("FAIL alt_data_b k%0d: got %0d want 2", k, bus.rd_data_b); end
         end
         step();
      end
      n_cmp++; if (pulses_a != 5) begin n_err++; $display("FAIL alt_count_a: got %0d want 5", pulses_a); end
      n_cmp++; if (pulses_b != 5) begin n_err++; $display("FAIL alt_count_b: got %0d want 5", pulses_b); end
   endtask

   // A writes addr 5 = 3, B reads addr 5 in the very next cycle.
   task automatic test_write_then_read;
      drive_a(1'b1, 5, 3);
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_err++; $display("FAIL raw_gnt_a: got %b want 1", bus.gnt_a); end
      step();
      idle_inputs();
      drive_b(1'b0, 5, 0);
      #1;
      n_cmp++; if (bus.gnt_b !== 1'b1) begin n_err++; $display("FAIL raw_gnt_b: got %b want 1", bus.gnt_b); end
      step();
      idle_inputs();
      #1;
      n_cmp++; if (bus.rd_valid_b !== 1'b0) begin n_err++; $display("FAIL raw_early_valid: got %b want 0", bus.rd_valid_b); end
      step();
      n_cmp++; if (bus.rd_valid_b !== 1'b1 || bus.rd_data_b !== 3'd3) begin
         n_err++; $display("FAIL raw_data: valid %b data %0d want valid 1 data 3", bus.rd_valid_b, bus.rd_data_b);
      end
      step();
      n_cmp++; if (bus.rd_valid_b !== 1'b0 || bus.rd_data_b !== 3'd3) begin
         n_err++; $display("FAIL raw_pulse_end: valid %b data %0d want valid 0 data 3", bus.rd_valid_b, bus.rd_data_b);
      end
   endtask

   // Reset with two reads of addr 7 (=6) in flight; contents must be re-zeroed.
   task automatic test_reset_inflight;
      drive_a(1'b1, 7, 6);
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_err++; $display("FAIL rst_wr_gnt: got %b want 1", bus.gnt_a); end
      step();
      drive_a(1'b0, 7, 0);
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b1) begin n_err++; $display("FAIL rst_rd1_gnt: got %b want 1", bus.gnt_a); end
      step();
      idle_inputs();
      drive_b(1'b0, 7, 0);
      #1;
      n_cmp++; if (bus.gnt_b !== 1'b1) begin n_err++; $display("FAIL rst_rd2_gnt: got %b want 1", bus.gnt_b); end
      #2 reset = 1'b1;
      idle_inputs();
      #1;
      n_cmp++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done_drop: got %b want 0", bus.init_done); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus.rd_valid_a !== 1'b0 || bus.rd_valid_b !== 1'b0) begin
            n_err++; $display("FAIL rst_hold_valid i%0d: a %b b %b want 0 0", i, bus.rd_valid_a, bus.rd_valid_b);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         step();
         n_cmp++; if (bus.rd_valid_a !== 1'b0 || bus.rd_valid_b !== 1'b0 || bus.init_done !== 1'b0) begin
            n_err++; $display("FAIL rst_reinit cyc%0d: va %b vb %b done %b want 0 0 0", i, bus.rd_valid_a, bus.rd_valid_b, bus.init_done);
         end
      end
      step();
      n_cmp++; if (bus.init_done !== 1'b1) begin n_err++; $display("FAIL rst_reinit_done: got %b want 1", bus.init_done); end
      // Load a nonzero value into rd_data_a first so the zero read of addr 7 is distinguishable.
      drive_a(1'b1, 0, 5);
      step();
      drive_a(1'b0, 0, 0);
      step();
      drive_a(1'b0, 7, 0);
      step();
      idle_inputs();
      #1;
      n_cmp++; if (bus.rd_valid_a !== 1'b1 || bus.rd_data_a !== 3'd5) begin
         n_err++; $display("FAIL rst_probe_addr0: valid %b data %0d want valid 1 data 5", bus.rd_valid_a, bus.rd_data_a);
      end
      step();
      n_cmp++; if (bus.rd_valid_a !== 1'b1 || bus.rd_data_a !== 3'd0) begin
         n_err++; $display("FAIL rst_addr7_zero: valid %b data %0d want valid 1 data 0", bus.rd_valid_a, bus.rd_data_a);
      end
   endtask

   // req_a held across reset and the whole sweep: granted on the first RUN cycle.
   task automatic test_req_during_init;
      idle_inputs();
      drive_a(1'b0, 3, 0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.gnt_a !== 1'b0) begin n_err++; $display("FAIL init_gnt cyc0: got %b want 0", bus.gnt_a); end
      for (int i = 1; i <= 31; i++) begin
         step();
         n_cmp++; if (bus.gnt_a !== 1'b0) begin n_err++; $display("FAIL init_gnt cyc%0d: got %b want 0", i, bus.gnt_a); end
      end
      step();
      n_cmp++; if (bus.gnt_a !== 1'b1 || bus.init_done !== 1'b1) begin
         n_err++; $display("FAIL init_first_run: gnt_a %b done %b want 1 1", bus.gnt_a, bus.init_done);
      end
      step();
      idle_inputs();
      step();
      n_cmp++; if (bus.rd_valid_a !== 1'b1 || bus.rd_data_a !== 3'd0) begin
         n_err++; $display("FAIL init_first_read: valid %b data %0d want valid 1 data 0", bus.rd_valid_a, bus.rd_data_a);
      end
      step();
      n_cmp++; if (bus.rd_valid_a !== 1'b0) begin n_err++; $display("FAIL init_first_read_end: got %b want 0", bus.rd_valid_a); end
   endtask

   initial begin
      test_reset();
      test_init_clear();
      test_write_pattern();
      test_alternate();
      test_write_then_read();
      test_reset_inflight();
      test_req_during_init();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
